// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 16;

  // Width of a counter that wraps naturally every os ticks (os is a power of 2).
  function automatic int tick_w(input int os);
    return $clog2(os);
  endfunction

endpackage

// File: rtl/rx_tick_counter.sv
// Oversample tick counter: advances on inc, clears on clr, and flags the
// sampling point of the current bit (half a bit into START, end of the bit
// period elsewhere).
module rx_tick_counter import uart_pkg::*; #(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  input  logic half,
  output logic mid
);

  localparam int TICK_W = tick_w(OVERSAMPLE);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE/2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

  logic [TICK_W-1:0] tick_cnt;

  // Count oversample ticks; clear has priority so a new state starts at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    tick_cnt <= '0;
    else if (clr) tick_cnt <= '0;
    else if (inc) tick_cnt <= tick_cnt + 1'b1;
  end

  // Sampling point: half a bit after the start edge, then one full bit apart.
  always_comb begin
    mid = inc && (half ? (tick_cnt == HALF_LAST) : (tick_cnt == FULL_LAST));
  end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start detection, mid-bit sampling from the
// oversample tick, LSB-first assembly, stop check and one-clk result pulses.
// Optional parity frame bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_controller import uart_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx_EN,
  input  logic                 sample_ENABLE,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_FERROR,
  output logic                 Rx_PERROR,
  output logic                 Rx_BUSY
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic                 rxd_meta, rxd_s;
  logic                 mid, tick_clr;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_s    <= rxd_meta;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a low enable overrides everything, including a start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (sample_ENABLE && !rxd_s) state_next = START;
      START: if (mid) state_next = rxd_s ? IDLE : DATA;
      DATA:  if (mid && bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
        state_next = PARITY;
`else
        state_next = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid) state_next = STOP;
`endif
      STOP:  if (mid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!Rx_EN) state_next = IDLE;
  end

  // Tick counter restarts on every state change and while disabled.
  always_comb begin
    tick_clr = (state_next != state) || !Rx_EN;
  end

  rx_tick_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .inc   (sample_ENABLE),
    .clr   (tick_clr),
    .half  (state == START),
    .mid   (mid)
  );

  // Data bit shifter; holds a partial word only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (Rx_EN && state == DATA && mid) shift_reg[bit_idx] <= rxd_s;
  end

`ifdef UART_RX_PARITY_EN
  logic parity_ok;

  // Parity verdict is taken at the parity bit's mid sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                parity_ok <= 1'b1;
    else if (Rx_EN && state == PARITY && mid) parity_ok <= ((^shift_reg) ^ rxd_s) == (PARITY_ODD != 0);
  end

  // Bit index, result word and the one-clk result pulses (stop error wins).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx   <= '0;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_FERROR <= 1'b0;
      Rx_PERROR <= 1'b0;
    end else begin
      Rx_VALID  <= 1'b0;
      Rx_FERROR <= 1'b0;
      Rx_PERROR <= 1'b0;
      if (state != DATA || !Rx_EN) bit_idx <= '0;
      else if (mid)                bit_idx <= bit_idx + 1'b1;
      if (Rx_EN && state == STOP && mid) begin
        Rx_DATA <= shift_reg;
        if (!rxd_s)          Rx_FERROR <= 1'b1;
        else if (!parity_ok) Rx_PERROR <= 1'b1;
        else                 Rx_VALID  <= 1'b1;
      end
    end
  end
`else
  // Bit index, result word and the one-clk result pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx   <= '0;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      Rx_VALID  <= 1'b0;
      Rx_FERROR <= 1'b0;
      if (state != DATA || !Rx_EN) bit_idx <= '0;
      else if (mid)                bit_idx <= bit_idx + 1'b1;
      if (Rx_EN && state == STOP && mid) begin
        Rx_DATA <= shift_reg;
        if (!rxd_s) Rx_FERROR <= 1'b1;
        else        Rx_VALID  <= 1'b1;
      end
    end
  end

  assign Rx_PERROR = 1'b0;
`endif

  assign Rx_BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Scoreboard bench for uart_rx_controller: stimulus pushes the expected
// result pulse, a negedge monitor pops and compares whenever a pulse appears.
module tb_uart_rx_controller;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int PARITY_ODD = 0;
  localparam int DIV        = 4;
  localparam int BIT_CLKS   = OVERSAMPLE * DIV;

  localparam logic [2:0] K_VALID  = 3'b001;
  localparam logic [2:0] K_FERROR = 3'b010;
  localparam logic [2:0] K_PERROR = 3'b100;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       Rx_EN;
  logic       sample_ENABLE;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;
  logic       Rx_BUSY;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_rx_controller #(
    .DATA_BITS  (DATA_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Rx_EN         (Rx_EN),
    .sample_ENABLE (sample_ENABLE),
    .RxD           (RxD),
    .Rx_DATA       (Rx_DATA),
    .Rx_VALID      (Rx_VALID),
    .Rx_FERROR     (Rx_FERROR),
    .Rx_PERROR     (Rx_PERROR),
    .Rx_BUSY       (Rx_BUSY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_pulse(input logic [2:0] k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip);
    RxD = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      RxD = d[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RxD = (^d) ^ (PARITY_ODD != 0) ^ par_flip;
    repeat (BIT_CLKS) @(negedge clk);
`endif
    RxD = stop_bit;
    repeat (BIT_CLKS) @(negedge clk);
    RxD = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * BIT_CLKS) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Free-running oversample tick: one clk high every DIV clks.
  initial begin
    int div;
    div = 0;
    sample_ENABLE = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % DIV;
      sample_ENABLE = (div == 0);
    end
  end

  // Monitor: every result pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (Rx_VALID || Rx_FERROR || Rx_PERROR) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, Rx_PERROR, Rx_FERROR, Rx_VALID}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", {29'd0, Rx_PERROR, Rx_FERROR, Rx_VALID}, {29'd0, e.kind});
        chk("rx_data", {24'd0, Rx_DATA}, {24'd0, e.data});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    Rx_EN = 1'b1;
    RxD   = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data",   {24'd0, Rx_DATA}, 0);
    chk("reset_valid",  {31'd0, Rx_VALID}, 0);
    chk("reset_ferror", {31'd0, Rx_FERROR}, 0);
    chk("reset_perror", {31'd0, Rx_PERROR}, 0);
    chk("reset_busy",   {31'd0, Rx_BUSY}, 0);
    reset = 1'b0;

    // Idle line for 1000 ticks.
    for (int k = 0; k < 4; k++) begin
      repeat (250 * DIV) @(negedge clk);
      chk("idle_busy", {31'd0, Rx_BUSY}, 0);
    end

    // Good frame 0xA5.
    expect_pulse(K_VALID, 8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_drain("a5_drain");
    repeat (2 * BIT_CLKS) @(negedge clk);
    chk("a5_busy_after", {31'd0, Rx_BUSY}, 0);

    // Framing error on 0x3C.
    expect_pulse(K_FERROR, 8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0);
    wait_drain("3c_drain");
    repeat (2 * BIT_CLKS) @(negedge clk);

    // Four-tick low glitch: false start, back to idle.
    RxD = 1'b0;
    repeat (4 * DIV) @(negedge clk);
    RxD = 1'b1;
    chk("glitch_busy", {31'd0, Rx_BUSY}, 1);
    repeat (BIT_CLKS) @(negedge clk);
    chk("glitch_idle", {31'd0, Rx_BUSY}, 0);
    chk("glitch_keeps_data", {24'd0, Rx_DATA}, 32'h3C);

    // Rx_EN dropped during bit 3 of 0xFF.
    RxD = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    RxD = 1'b1;
    repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    chk("cancel_busy_before", {31'd0, Rx_BUSY}, 1);
    Rx_EN = 1'b0;
    @(negedge clk);
    chk("cancel_busy_after", {31'd0, Rx_BUSY}, 0);
    repeat (7 * BIT_CLKS) @(negedge clk);
    chk("cancel_keeps_data", {24'd0, Rx_DATA}, 32'h3C);
    Rx_EN = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    expect_pulse(K_VALID, 8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    wait_drain("01_drain");
    repeat (BIT_CLKS) @(negedge clk);

    // Back-to-back frames with no idle gap.
    expect_pulse(K_VALID, 8'h81);
    expect_pulse(K_VALID, 8'h7E);
    send_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_drain("b2b_drain");
    repeat (BIT_CLKS) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // Wrong parity on 0x07.
    expect_pulse(K_PERROR, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_drain("07_drain");
    repeat (BIT_CLKS) @(negedge clk);
`endif

    // Reset asserted mid-DATA.
    RxD = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    RxD = 1'b1;
    repeat (2 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
    chk("midreset_busy_before", {31'd0, Rx_BUSY}, 1);
    reset = 1'b1;
    #1;
    chk("midreset_data",  {24'd0, Rx_DATA}, 0);
    chk("midreset_busy",  {31'd0, Rx_BUSY}, 0);
    chk("midreset_pulses", {29'd0, Rx_PERROR, Rx_FERROR, Rx_VALID}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8 * BIT_CLKS) @(negedge clk);
    chk("midreset_idle", {31'd0, Rx_BUSY}, 0);
    expect_pulse(K_VALID, 8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_drain("5a_drain");
    repeat (BIT_CLKS) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
